// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The master drives the request and address; the slave returns ack and read data.
interface fetch_unit_if;
  logic        Fo_imemReq;
  logic [31:0] Fo_imemAddr;
  logic        Fi_imemAck;
  logic [31:0] Fi_imemRdata;

  modport master (output Fo_imemReq, Fo_imemAddr, input Fi_imemAck, Fi_imemRdata);
  modport slave  (input Fo_imemReq, Fo_imemAddr, output Fi_imemAck, Fi_imemRdata);
endinterface

// File: rtl/fetch_unit.sv
// RV32I IF stage plus IF/ID register: owns the PC, fetches over a req/ack bus,
// buffers up to two words and presents {inst, pc, pc+4} to ID.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Fi_stall,
  input  logic                Ei_redirect,
  input  logic [31:0]         Ei_redirectPC,
  fetch_unit_if.master        imem,
  output logic [31:0]         Do_inst,
  output logic [31:0]         Do_pc,
  output logic [31:0]         Do_pcPlus4,
  output logic                Do_valid
);
  typedef enum logic {FETCH, DISCARD} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] target_q, target_d;
  logic [31:0] qi_q [2];
  logic [31:0] qi_d [2];
  logic [31:0] qp_q [2];
  logic [31:0] qp_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d, pc_q, pc_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        accept, pop, push, bypass, wr_idx;
  logic [31:0] redirect_pc;

  assign accept      = req_q && imem.Fi_imemAck;
  assign redirect_pc = {Ei_redirectPC[31:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    target_d = target_q;
    qi_d     = qi_q;
    qp_d     = qp_q;
    cnt_d    = cnt_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    pop      = 1'b0;
    push     = 1'b0;
    bypass   = 1'b0;
    wr_idx   = 1'b0;
    if (Ei_redirect) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
      cnt_d   = 2'd0;
      // An unacknowledged request must still complete; its data is thrown away.
      if (req_q && !imem.Fi_imemAck) begin
        state_d  = DISCARD;
        target_d = redirect_pc;
      end else begin
        state_d = FETCH;
        addr_d  = redirect_pc;
        req_d   = 1'b1;
      end
    end else if (state_q == DISCARD) begin
      if (imem.Fi_imemAck) begin
        state_d = FETCH;
        addr_d  = target_q;
        req_d   = 1'b1;
      end
    end else begin
      if (!Fi_stall) begin
        if (cnt_q != 2'd0) begin
          inst_d  = qi_q[0];
          pc_d    = qp_q[0];
          pc4_d   = qp_q[0] + 32'd4;
          valid_d = 1'b1;
          pop     = 1'b1;
        end else if (accept) begin
          inst_d  = imem.Fi_imemRdata;
          pc_d    = addr_q;
          pc4_d   = addr_q + 32'd4;
          valid_d = 1'b1;
          bypass  = 1'b1;
        end else begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      end
      push = accept && !bypass;
      if (pop) begin
        qi_d[0] = qi_q[1];
        qp_d[0] = qp_q[1];
      end
      // Slot for the new word after the head (if any) has been popped.
      wr_idx = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);
      if (push) begin
        qi_d[wr_idx] = imem.Fi_imemRdata;
        qp_d[wr_idx] = addr_q;
      end
      cnt_d = cnt_q - {1'b0, pop} + {1'b0, push};
      if (accept) addr_d = addr_q + 32'd4;
      req_d = (cnt_d < 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      req_q    <= 1'b0;
      addr_q   <= {RESET_PC[31:2], 2'b00};
      target_q <= {RESET_PC[31:2], 2'b00};
      cnt_q    <= 2'd0;
      inst_q   <= NOP_INST;
      pc_q     <= 32'd0;
      pc4_q    <= 32'd4;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
    end
    for (int i = 0; i < 2; i++) begin
      qi_q[i] <= qi_d[i];
      qp_q[i] <= qp_d[i];
    end
  end

  assign imem.Fo_imemReq  = req_q;
  assign imem.Fo_imemAddr = addr_q;
  assign Do_inst          = inst_q;
  assign Do_pc            = pc_q;
  assign Do_pcPlus4       = pc4_q;
  assign Do_valid         = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios against a queue-based reference of the
// fetch stream, compared every cycle, plus hand-computed expectations per scenario.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] rpc;
  logic [31:0] Do_inst, Do_pc, Do_pcPlus4;
  logic        Do_valid;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .reset        (reset),
    .Fi_stall     (stall),
    .Ei_redirect  (redirect),
    .Ei_redirectPC(rpc),
    .imem         (imem),
    .Do_inst      (Do_inst),
    .Do_pc        (Do_pc),
    .Do_pcPlus4   (Do_pcPlus4),
    .Do_valid     (Do_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int unsigned waits = 0;
  int unsigned wcnt = 0;
  logic force_ack = 1'b0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
  endtask

  // One cycle: wait for the falling edge, then answer the memory request.
  task automatic tick();
    @(negedge clk);
    if (force_ack) begin
      imem.Fi_imemAck = 1'b1; imem.Fi_imemRdata = 32'hDEAD_BEEF; wcnt = 0;
    end else if (imem.Fo_imemReq !== 1'b1) begin
      imem.Fi_imemAck = 1'b0; imem.Fi_imemRdata = BAD; wcnt = 0;
    end else if (wcnt >= waits) begin
      imem.Fi_imemAck = 1'b1; imem.Fi_imemRdata = mdata(imem.Fo_imemAddr); wcnt = 0;
    end else begin
      imem.Fi_imemAck = 1'b0; imem.Fi_imemRdata = BAD; wcnt++;
    end
  endtask

  // Reference: fetched words go into a FIFO tagged with their PC; ID takes the oldest.
  logic [63:0] fifo [$];
  logic        m_init = 1'b0;
  logic        m_req, m_disc, m_valid, m_acc;
  logic [31:0] m_addr, m_tgt, m_inst, m_pc;
  logic [63:0] m_e;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_init = 1'b1; m_req = 1'b0; m_disc = 1'b0; m_addr = 32'h0; m_tgt = 32'h0;
      m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0; fifo.delete();
    end else if (m_init) begin
      m_acc = m_req && imem.Fi_imemAck;
      if (redirect) begin
        m_inst = NOP; m_valid = 1'b0; fifo.delete();
        if (m_req && !imem.Fi_imemAck) begin
          m_disc = 1'b1; m_tgt = rpc & 32'hFFFF_FFFC;
        end else begin
          m_disc = 1'b0; m_addr = rpc & 32'hFFFF_FFFC; m_req = 1'b1;
        end
      end else if (m_disc) begin
        if (imem.Fi_imemAck) begin
          m_disc = 1'b0; m_addr = m_tgt; m_req = 1'b1;
        end
      end else begin
        if (m_acc) begin
          fifo.push_back({m_addr, imem.Fi_imemRdata});
          m_addr = m_addr + 32'd4;
        end
        if (!stall) begin
          if (fifo.size() > 0) begin
            m_e = fifo.pop_front();
            m_pc = m_e[63:32]; m_inst = m_e[31:0]; m_valid = 1'b1;
          end else begin
            m_inst = NOP; m_valid = 1'b0;
          end
        end
        m_req = (fifo.size() < 2);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("Do_inst", Do_inst, m_inst);
      chk("Do_pc", Do_pc, m_pc);
      chk("Do_pcPlus4", Do_pcPlus4, m_pc + 32'd4);
      chk("Do_valid", 32'(Do_valid), 32'(m_valid));
      chk("imemReq", 32'(imem.Fo_imemReq), 32'(m_req));
      chk("imemAddr", imem.Fo_imemAddr, m_addr);
      if (Do_valid === 1'b1)
        $display("ID t=%0t pc=%08h inst=%08h", $time, Do_pc, Do_inst);
    end
  end

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'h0; force_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  int n;

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'h0;
    imem.Fi_imemAck = 1'b0; imem.Fi_imemRdata = BAD;

    // Zero-wait streaming
    waits = 0;
    do_reset();
    chk("L_rst_inst", Do_inst, NOP);
    chk("L_rst_pc4", Do_pcPlus4, 32'h4);
    chk("L_rst_req", 32'(imem.Fo_imemReq), 32'h0);
    tick();
    chk("L_s1_req", 32'(imem.Fo_imemReq), 32'h1);
    chk("L_s1_addr0", imem.Fo_imemAddr, 32'h0);
    tick();
    chk("L_s1_valid", 32'(Do_valid), 32'h1);
    chk("L_s1_inst0", Do_inst, 32'hC0DE_0000);
    chk("L_s1_addr4", imem.Fo_imemAddr, 32'h4);
    tick();
    chk("L_s1_pc4", Do_pc, 32'h4);
    chk("L_s1_pcp4", Do_pcPlus4, 32'h8);
    repeat (6) tick();

    // Three wait states
    waits = 3;
    do_reset();
    repeat (4) tick();
    chk("L_s2_addr", imem.Fo_imemAddr, 32'h0);
    chk("L_s2_novalid", 32'(Do_valid), 32'h0);
    tick();
    chk("L_s2_valid", 32'(Do_valid), 32'h1);
    chk("L_s2_inst", Do_inst, 32'hC0DE_0000);
    tick();
    chk("L_s2_bubble", 32'(Do_valid), 32'h0);
    repeat (10) tick();

    // Stall for four cycles with zero-wait memory
    waits = 0;
    do_reset();
    repeat (3) tick();
    stall = 1'b1;
    repeat (2) tick();
    chk("L_s3_reqdrop", 32'(imem.Fo_imemReq), 32'h0);
    chk("L_s3_hold", Do_pc, 32'h4);
    repeat (2) tick();
    stall = 1'b0;
    tick(); chk("L_s3_pc8", Do_pc, 32'h8);
    tick(); chk("L_s3_pcC", Do_pc, 32'hC);
    tick(); chk("L_s3_pc10", Do_pc, 32'h10);
    repeat (4) tick();

    // Redirect while the request to 0x8 is waiting
    waits = 3;
    do_reset();
    n = 0;
    do begin tick(); n++; end while (!(imem.Fo_imemReq && imem.Fo_imemAddr == 32'h8) && n < 20);
    chk("L_s4_reach8", imem.Fo_imemAddr, 32'h8);
    redirect = 1'b1; rpc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("L_s4_hold8", imem.Fo_imemAddr, 32'h8);
    chk("L_s4_flush", 32'(Do_valid), 32'h0);
    n = 0;
    do begin tick(); n++; end while (imem.Fo_imemAddr == 32'h8 && n < 10);
    chk("L_s4_addr100", imem.Fo_imemAddr, 32'h100);
    n = 0;
    while (Do_valid !== 1'b1 && n < 12) begin tick(); n++; end
    chk("L_s4_valid", 32'(Do_valid), 32'h1);
    chk("L_s4_pc", Do_pc, 32'h100);
    chk("L_s4_pcp4", Do_pcPlus4, 32'h104);
    chk("L_s4_inst", Do_inst, 32'hC0DE_0100);
    repeat (4) tick();

    // Two redirects while discarding: the newer target wins
    waits = 2;
    do_reset();
    n = 0;
    do begin tick(); n++; end while (!(imem.Fo_imemReq && imem.Fo_imemAddr == 32'h4) && n < 20);
    redirect = 1'b1; rpc = 32'h100;
    tick();
    rpc = 32'h306;
    tick();
    redirect = 1'b0;
    n = 0;
    do begin tick(); n++; end while (imem.Fo_imemAddr == 32'h4 && n < 10);
    chk("L_s4b_newest", imem.Fo_imemAddr, 32'h304);
    repeat (8) tick();

    // Redirect to 0x203 with stall and a full queue
    waits = 0;
    do_reset();
    repeat (2) tick();
    stall = 1'b1;
    n = 0;
    do begin tick(); n++; end while (imem.Fo_imemReq && n < 10);
    chk("L_s5_full", 32'(imem.Fo_imemReq), 32'h0);
    chk("L_s5_held", Do_pc, 32'h0);
    redirect = 1'b1; rpc = 32'h203;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("L_s5_nop", Do_inst, NOP);
    chk("L_s5_inval", 32'(Do_valid), 32'h0);
    chk("L_s5_addr", imem.Fo_imemAddr, 32'h200);
    tick();
    chk("L_s5_pc", Do_pc, 32'h200);
    chk("L_s5_valid", 32'(Do_valid), 32'h1);
    repeat (4) tick();

    // Reset mid-wait with an ack in the same cycle
    waits = 3;
    do_reset();
    tick();
    force_ack = 1'b1;
    tick();
    reset = 1'b1; force_ack = 1'b0;
    tick();
    chk("L_s6_inst", Do_inst, NOP);
    chk("L_s6_pc", Do_pc, 32'h0);
    chk("L_s6_valid", 32'(Do_valid), 32'h0);
    chk("L_s6_req", 32'(imem.Fo_imemReq), 32'h0);
    reset = 1'b0;
    tick();
    chk("L_s6_addr", imem.Fo_imemAddr, 32'h0);
    n = 0;
    while (Do_valid !== 1'b1 && n < 12) begin tick(); n++; end
    chk("L_s6_firstinst", Do_inst, 32'hC0DE_0000);
    chk("L_s6_firstpc", Do_pc, 32'h0);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
